core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge active.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port opcode, input, 7 bits: opcode from the registered instruction decoder, valid from the cycle after DECODE.
REQ-004 The block SHALL have the port br_taken, input, 1 bit: branch compare result, valid in EXEC.
REQ-005 The block SHALL have the ports imem_req (output, 1 bit) and imem_ack (input, 1 bit): instruction fetch handshake.
REQ-006 The block SHALL have the ports dmem_req (output, 1 bit), dmem_we (output, 1 bit) and dmem_ack (input, 1 bit): data memory handshake.
REQ-007 The block SHALL have the outputs ir_we, pc_we and rf_we, 1 bit each: write enables for the instruction register, PC and register file.
REQ-008 The block SHALL have the output pc_sel, 2 bits: 00 = pc+4, 01 = branch target, 10 = jal target, 11 = jalr target.
REQ-009 The block SHALL have the output wb_sel, 2 bits: 00 = ALU, 01 = memory data, 10 = pc+4, 11 = immediate (lui).
REQ-010 The block SHALL have the outputs alu_src_a (0 = rs1, 1 = pc) and alu_src_b (0 = rs2, 1 = immediate), 1 bit each.
REQ-011 The block SHALL have the output illegal, 1 bit: sticky flag for an unknown opcode.
REQ-012 The block SHALL have the output instret, 32 bits: retired-instruction count, present only when PERF_CNT_EN is defined.

Function
REQ-013 The block SHALL implement a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB and TRAP; all outputs SHALL be decoded from the registered state and the held opcode.
REQ-014 In FETCH, imem_req SHALL stay high until imem_ack; in the ack cycle ir_we SHALL be 1 for one cycle and the next state SHALL be DECODE.
REQ-015 DECODE SHALL last exactly 1 cycle with all enables low, to cover the decoder register latency; the next state SHALL be EXEC.
REQ-016 In EXEC, opcodes 0110011, 0010011, 0110111 and 0010111 SHALL go to WB; 0000011 and 0100011 SHALL go to MEM; 1101111 and 1100111 SHALL go to WB; 1100011 SHALL go to FETCH; any other opcode SHALL go to TRAP.
REQ-017 A branch in EXEC SHALL assert pc_we=1 for one cycle, with pc_sel=01 if br_taken, else pc_sel=00.
REQ-018 In EXEC, alu_src_b SHALL be 1 for itype, load, store, lui, auipc and jalr, and 0 otherwise; alu_src_a SHALL be 1 only for auipc.
REQ-019 In MEM, dmem_req SHALL stay high until dmem_ack, and dmem_we SHALL be 1 only for a store; on ack, a load SHALL go to WB, and a store SHALL assert pc_we with pc_sel=00 and go to FETCH.
REQ-020 WB SHALL last 1 cycle and assert rf_we=1 and pc_we=1: jal gives pc_sel=10, jalr gives pc_sel=11, all others give pc_sel=00; wb_sel SHALL be 01 for a load, 10 for jal/jalr, 11 for lui, and 00 otherwise.
REQ-021 pc_we SHALL pulse exactly once per instruction; rf_we SHALL never be asserted for a branch or store.
REQ-022 The minimum latency SHALL be 4 cycles (ALU/jump: FETCH-DECODE-EXEC-WB, with zero-wait ack) and 5 cycles for a load.
REQ-023 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored; a request SHALL never be dropped before its ack.
REQ-024 In TRAP, illegal SHALL be 1 and all enables and requests SHALL be 0; TRAP SHALL be left only by reset.

Reset
REQ-025 rst_n low SHALL asynchronously force state FETCH, illegal=0, instret=0 and all outputs to 0, even mid-handshake; the pending request SHALL be abandoned.
REQ-026 imem_req SHALL rise in the first clk edge cycle after rst_n deasserts.

Configuration
REQ-027 With PERF_CNT_EN defined, instret SHALL increment by 1 in every cycle that pc_we=1, wrapping from 0xFFFFFFFF to 0.
REQ-028 Without PERF_CNT_EN, the instret port and its counter SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-029 The package core_pkg SHALL hold the opcode constants, the FSM state encoding, and the pc_sel and wb_sel encodings.
REQ-030 The counter SHALL be the sub-module perf_counter, instantiated only under PERF_CNT_EN.

Verification
REQ-031 add (opcode 0110011) with zero-wait acks -> ir_we in cycle 1, rf_we=1, pc_we=1, pc_sel=00, wb_sel=00 in cycle 4.
REQ-032 lw (0000011) with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0, then WB with wb_sel=01.
REQ-033 beq (1100011) with br_taken=1, then with br_taken=0 -> pc_sel=01, then pc_sel=00, pc_we pulse in EXEC, rf_we=0 throughout.
REQ-034 Opcode 1111111 -> TRAP with illegal=1 held for 100 cycles; rst_n pulse -> illegal=0 and imem_req rises.
REQ-035 rst_n asserted while dmem_req=1 -> all outputs 0 within the same cycle; after release a fresh fetch starts.
REQ-036 PERF_CNT_EN with 5 mixed instructions -> instret=5; instret preloaded to 0xFFFFFFFF plus one instruction -> instret=0.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// Shared encodings for the multi-cycle instruction sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: RV32 major opcodes, FSM state encoding, pc_sel and wb_sel encodings.
package core_pkg;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_t;

  // Opcodes whose ALU operand B is the immediate.
  function automatic logic uses_imm(input logic [6:0] op);
    return (op == OP_ITYPE) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_LUI)   || (op == OP_AUIPC) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Bundle of the sequencer's decoder inputs, memory handshakes and datapath controls.
// Latency: n/a (wiring only).
// Backpressure: imem/dmem requests are held until their ack; no other stalls.
//
// master: the sequencer (drives requests and enables); slave: datapath/memories.
interface core_sequencer_if;
  logic [6:0] opcode;
  logic       br_taken;
  logic       imem_req;
  logic       imem_ack;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ack;
  logic       ir_we;
  logic       pc_we;
  logic       rf_we;
  logic [1:0] pc_sel;
  logic [1:0] wb_sel;
  logic       alu_src_a;
  logic       alu_src_b;
  logic       illegal;

  modport master (
    input  opcode, br_taken, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we,
           pc_sel, wb_sel, alu_src_a, alu_src_b, illegal
  );

  modport slave (
    output opcode, br_taken, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we,
           pc_sel, wb_sel, alu_src_a, alu_src_b, illegal
  );
endinterface

// File: rtl/core_sequencer_perf_counter.sv
// Retired-instruction counter: counts cycles with inc high, wrapping at 2^32.
// Latency: count reflects an inc one cycle later.
// Backpressure: none.
//
// Ports: clk, rst_n (async active-low), inc, count[31:0].
module perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: FETCH-DECODE-EXEC-(MEM)-WB with a sticky TRAP.
// Latency: 4 cycles ALU/jump, 5 load, 4 store, 3 branch with zero-wait acks.
// Backpressure: imem_req/dmem_req held until ack; stray acks are ignored.
//
// Ports: clk, rst_n (async active-low), bus (core_sequencer_if.master),
// instret[31:0] only when PERF_CNT_EN is defined.
// Optional feature macro: PERF_CNT_EN (retired-instruction counter).
module core_sequencer
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  core_sequencer_if.master bus
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]      instret
`endif
);

  state_t     state_q, state_d;
  logic [6:0] op_q;
  // Low only between reset release and the first clock edge, so every output
  // stays 0 while reset is asserted and imem_req rises on the first edge.
  logic       run_q;

  logic       imem_req, dmem_req, dmem_we;
  logic       ir_we, pc_we, rf_we;
  pc_sel_t    pc_sel;
  wb_sel_t    wb_sel;
  logic       alu_src_a, alu_src_b, illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      // The decoder output is only valid in EXEC; keep it for MEM and WB.
      if (state_q == ST_EXEC) begin
        op_q <= bus.opcode;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    wb_sel    = WB_ALU;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (run_q) begin
          imem_req = 1'b1;
          if (bus.imem_ack) begin
            ir_we   = 1'b1;
            state_d = ST_DECODE;
          end
        end
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        alu_src_b = uses_imm(bus.opcode);
        alu_src_a = (bus.opcode == OP_AUIPC);
        case (bus.opcode)
          OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC,
          OP_JAL, OP_JALR:    state_d = ST_WB;
          OP_LOAD, OP_STORE:  state_d = ST_MEM;
          OP_BRANCH: begin
            // A branch retires here: its single PC update happens in EXEC.
            pc_we   = 1'b1;
            pc_sel  = bus.br_taken ? PC_BRANCH : PC_PLUS4;
            state_d = ST_FETCH;
          end
          default:            state_d = ST_TRAP;
        endcase
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        if (bus.dmem_ack) begin
          if (op_q == OP_STORE) begin
            // Stores have nothing to write back; retire on the ack.
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        case (op_q)
          OP_JAL:  pc_sel = PC_JAL;
          OP_JALR: pc_sel = PC_JALR;
          default: pc_sel = PC_PLUS4;
        endcase
        case (op_q)
          OP_LOAD:         wb_sel = WB_MEM;
          OP_JAL, OP_JALR: wb_sel = WB_PC4;
          OP_LUI:          wb_sel = WB_IMM;
          default:         wb_sel = WB_ALU;
        endcase
        state_d = ST_FETCH;
      end

      ST_TRAP: begin
        illegal = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign bus.imem_req  = imem_req;
  assign bus.dmem_req  = dmem_req;
  assign bus.dmem_we   = dmem_we;
  assign bus.ir_we     = ir_we;
  assign bus.pc_we     = pc_we;
  assign bus.rf_we     = rf_we;
  assign bus.pc_sel    = pc_sel;
  assign bus.wb_sel    = wb_sel;
  assign bus.alu_src_a = alu_src_a;
  assign bus.alu_src_b = alu_src_b;
  assign bus.illegal   = illegal;

`ifdef PERF_CNT_EN
  perf_counter u_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_we),
    .count (instret)
  );
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: per-instruction phase traces from a reference model.
// Latency: n/a.
// Backpressure: randomized ack delays and stray acks outside their phase.
module tb_core_sequencer;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_sequencer_if bus();
`ifdef PERF_CNT_EN
  logic [31:0] instret;
  logic [31:0] icount = '0;
`endif

  core_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PERF_CNT_EN
    ,
    .instret (instret)
`endif
  );

  // One cycle of stimulus plus the output vector the model requires.
  // Vector: {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we,
  //          pc_sel[1:0], wb_sel[1:0], alu_src_a, alu_src_b, illegal}
  typedef struct {
    logic       ia;
    logic       da;
    logic       br;
    logic [6:0] op;
    logic [12:0] exp;
  } cyc_t;

  cyc_t        sched[$];
  logic [12:0] obs[$];
  logic [12:0] exp_cur = '0;
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          passes = 0;

  logic [6:0] legal_ops [9] = '{OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_LOAD,
                                OP_STORE, OP_JAL, OP_JALR, OP_BRANCH};

  function automatic logic [12:0] dut_vec();
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we,
            bus.rf_we, bus.pc_sel, bus.wb_sel, bus.alu_src_a, bus.alu_src_b,
            bus.illegal};
  endfunction

  function automatic logic [12:0] vec(input logic ireq, input logic dreq,
      input logic dwe, input logic irw, input logic pcw, input logic rfw,
      input logic [1:0] pcs, input logic [1:0] wbs, input logic a,
      input logic b, input logic ill);
    return {ireq, dreq, dwe, irw, pcw, rfw, pcs, wbs, a, b, ill};
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  // Reference model: expand one instruction into its cycle-by-cycle trace.
  task automatic build(input logic [6:0] op, input int idly, input int ddly,
                       input logic br, input int trap_len);
    cyc_t c;
    logic ld, st, mem;
    logic [1:0] pcs, wbs;
    ld  = (op == OP_LOAD);
    st  = (op == OP_STORE);
    mem = ld || st;
    // Fetch: request held through the wait cycles, ir_we on the ack cycle.
    for (int i = 0; i < idly; i++) begin
      c = '{ia: 1'b0, da: rbit(), br: rbit(), op: rop(),
            exp: vec(1,0,0,0,0,0,2'd0,2'd0,0,0,0)};
      sched.push_back(c);
    end
    c = '{ia: 1'b1, da: rbit(), br: rbit(), op: rop(),
          exp: vec(1,0,0,1,0,0,2'd0,2'd0,0,0,0)};
    sched.push_back(c);
    // Decode: everything quiet, stray acks must be ignored.
    c = '{ia: rbit(), da: rbit(), br: rbit(), op: rop(), exp: '0};
    sched.push_back(c);
    // Execute: operand selects; branches retire here.
    c = '{ia: rbit(), da: rbit(), br: br, op: op, exp: '0};
    if (op == OP_BRANCH)
      c.exp = vec(0,0,0,0,1,0, br ? 2'd1 : 2'd0, 2'd0, 0, 0, 0);
    else if (is_legal(op))
      c.exp = vec(0,0,0,0,0,0,2'd0,2'd0, op == OP_AUIPC,
                  op inside {OP_ITYPE, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_JALR}, 0);
    sched.push_back(c);
    if (op == OP_BRANCH) return;
    if (!is_legal(op)) begin
      for (int i = 0; i < trap_len; i++) begin
        c = '{ia: rbit(), da: rbit(), br: rbit(), op: rop(),
              exp: vec(0,0,0,0,0,0,2'd0,2'd0,0,0,1)};
        sched.push_back(c);
      end
      return;
    end
    if (mem) begin
      for (int i = 0; i < ddly; i++) begin
        c = '{ia: rbit(), da: 1'b0, br: rbit(), op: rop(),
              exp: vec(0,1,st,0,0,0,2'd0,2'd0,0,0,0)};
        sched.push_back(c);
      end
      c = '{ia: rbit(), da: 1'b1, br: rbit(), op: rop(),
            exp: vec(0,1,st,0,st,0,2'd0,2'd0,0,0,0)};
      sched.push_back(c);
      if (st) return;
    end
    pcs = (op == OP_JAL) ? 2'd2 : (op == OP_JALR) ? 2'd3 : 2'd0;
    wbs = ld ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 :
          (op == OP_LUI) ? 2'd3 : 2'd0;
    c = '{ia: rbit(), da: rbit(), br: rbit(), op: rop(),
          exp: vec(0,0,0,0,1,1,pcs,wbs,0,0,0)};
    sched.push_back(c);
  endtask

  task automatic play(input int n);
    for (int k = 0; k < n && sched.size() > 0; k++) begin
      cyc_t c;
      c = sched.pop_front();
      @(posedge clk); #1;
      bus.imem_ack = c.ia;
      bus.dmem_ack = c.da;
      bus.br_taken = c.br;
      bus.opcode   = c.op;
      exp_cur      = c.exp;
      chk_en       = 1'b1;
    end
  endtask

  task automatic sync();
    @(negedge clk); #1;
  endtask

  // Compare process: every active cycle against the model's expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [12:0] v;
      v = dut_vec();
      obs.push_back(v);
      chk("cycle_outputs", 32'(v), 32'(exp_cur));
`ifdef PERF_CNT_EN
      chk("instret", instret, icount);
      if (exp_cur[8]) icount = icount + 32'd1;
`endif
    end
  end

  task automatic do_reset(input string tag, input logic mid_mem);
    @(posedge clk); #1;
    chk_en = 1'b0;
    if (mid_mem) chk({tag, "_dmem_req_before"}, 32'(bus.dmem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk({tag, "_outs_in_reset"}, 32'(dut_vec()), 32'd0);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    sched.delete();
`ifdef PERF_CNT_EN
    icount = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk({tag, "_outs_after_release"}, 32'(dut_vec()), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_imem_req_rise"}, 32'(bus.imem_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, cnt, cnt_we, rf_any;
    logic [6:0] op;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.br_taken = 1'b0;
    bus.opcode   = '0;
    #1 chk("reset_outs", 32'(dut_vec()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("outs_before_first_edge", 32'(dut_vec()), 32'd0);
    @(posedge clk); #1;
    chk("imem_req_first_edge", 32'(bus.imem_req), 32'd1);

    // add, zero-wait
    obs.delete();
    build(OP_RTYPE, 0, 0, 1'b0, 0);
    play(sched.size()); sync();
    chk("add_cycles", obs.size(), 4);
    chk("add_c1_ir_we", 32'(obs[0][9]), 32'd1);
    chk("add_c4_outputs", 32'(obs[3]), 32'h180);

    // lw with dmem_ack three cycles late
    obs.delete();
    build(OP_LOAD, 0, 3, 1'b0, 0);
    play(sched.size()); sync();
    cnt = 0; cnt_we = 0;
    foreach (obs[i]) begin cnt += int'(obs[i][11]); cnt_we += int'(obs[i][10]); end
    chk("lw_dmem_req_cycles", cnt, 4);
    chk("lw_dmem_we_cycles", cnt_we, 0);
    chk("lw_wb_sel", 32'(obs[obs.size()-1][4:3]), 32'd1);

    // beq taken then not taken
    obs.delete();
    build(OP_BRANCH, 1, 0, 1'b1, 0);
    build(OP_BRANCH, 0, 0, 1'b0, 0);
    play(sched.size()); sync();
    rf_any = 0;
    foreach (obs[i]) rf_any |= int'(obs[i][7]);
    chk("beq_taken_pc_sel", 32'(obs[3][6:5]), 32'd1);
    chk("beq_taken_pc_we", 32'(obs[3][8]), 32'd1);
    chk("beq_nt_pc_sel", 32'(obs[6][6:5]), 32'd0);
    chk("beq_nt_pc_we", 32'(obs[6][8]), 32'd1);
    chk("beq_rf_we_never", rf_any, 0);

    // illegal opcode: trap held for 100 cycles, cleared only by reset
    build(7'b1111111, 0, 0, 1'b0, 100);
    play(sched.size()); sync();
    chk("trap_illegal_held", 32'(bus.illegal), 32'd1);
    do_reset("trap", 1'b0);

    // reset in the middle of a data access
    build(OP_LOAD, 0, 6, 1'b0, 0);
    play(5);
    do_reset("midmem", 1'b1);

`ifdef PERF_CNT_EN
    build(OP_RTYPE, 0, 0, 1'b0, 0);
    build(OP_LOAD, 1, 1, 1'b0, 0);
    build(OP_STORE, 0, 2, 1'b0, 0);
    build(OP_BRANCH, 0, 0, 1'b1, 0);
    build(OP_JAL, 0, 0, 1'b0, 0);
    build(OP_ITYPE, 2, 0, 1'b0, 0);
    play(sched.size() - 5);
    chk("instret_after_5", instret, 32'd5);
    force dut.u_perf.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.u_perf.cnt_q;
    icount = 32'hFFFF_FFFF;
    play(sched.size()); sync();
    chk("instret_wrap", instret, 32'd0);
`endif

    // randomized mix with random ack delays
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = rop(); while (is_legal(op));
        build(op, $urandom_range(0, 3), 0, rbit(), 5);
        play(sched.size());
        do_reset("rand_trap", 1'b0);
      end else begin
        n = $urandom_range(0, 8);
        build(legal_ops[n], $urandom_range(0, 3), $urandom_range(0, 3), rbit(), 0);
        play(sched.size());
      end
    end
    sync();
    chk_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
